// File: rtl/stream_demux_1x2.sv
// rtl/stream_demux_1x2.sv - 1-to-2 stream demultiplexer steering each word into one of two output FIFOs
module stream_demux_1x2 #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outA_data,
    output logic             outA_valid,
    input  logic             outA_ready,
    output logic [WIDTH-1:0] outB_data,
    output logic             outB_valid,
    input  logic             outB_ready,
    output logic [CW-1:0]    countA,
    output logic [CW-1:0]    countB
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Index 0 is FIFO A, index 1 is FIFO B.
    logic [WIDTH-1:0] r_mem [2][DEPTH];
    logic [PW-1:0]    r_wr  [2];
    logic [PW-1:0]    r_rd  [2];
    logic [CW-1:0]    r_cnt [2];

    logic [1:0] w_sel_onehot;
    logic [1:0] w_full;
    logic [1:0] w_valid;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_out_ready;

    always_comb begin
        w_sel_onehot = in_sel ? 2'b10 : 2'b01;
        w_out_ready  = {outB_ready, outA_ready};
        for (int i = 0; i < 2; i++) begin
            w_full[i]  = (r_cnt[i] == CW'(DEPTH));
            w_valid[i] = (r_cnt[i] != '0);
        end
        // Readiness depends only on occupancy, so a same-cycle pop never frees a full FIFO.
        in_ready = ~|(w_full & w_sel_onehot);
        w_push   = {2{in_valid & in_ready}} & w_sel_onehot;
        w_pop    = w_valid & w_out_ready;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                r_wr[i]  <= '0;
                r_rd[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i])
                    r_wr[i] <= r_wr[i] + PW'(1);
                if (w_pop[i])
                    r_rd[i] <= r_rd[i] + PW'(1);
                if (w_push[i] && !w_pop[i])
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                else if (w_pop[i] && !w_push[i])
                    r_cnt[i] <= r_cnt[i] - CW'(1);
            end
        end
    end

    // Storage needs no reset: data outputs are masked to zero while a FIFO is empty.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i])
                r_mem[i][r_wr[i]] <= in_data;
        end
    end

    assign outA_valid = w_valid[0];
    assign outB_valid = w_valid[1];
    assign outA_data  = w_valid[0] ? r_mem[0][r_rd[0]] : '0;
    assign outB_data  = w_valid[1] ? r_mem[1][r_rd[1]] : '0;
    assign countA     = r_cnt[0];
    assign countB     = r_cnt[1];

endmodule

// File: tb/tb_stream_demux_1x2.sv
// tb/tb_stream_demux_1x2.sv - self-checking bench for stream_demux_1x2 against a queue-based reference
module tb_stream_demux_1x2;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] outA_data;
    logic             outA_valid;
    logic             outA_ready;
    logic [WIDTH-1:0] outB_data;
    logic             outB_valid;
    logic             outB_ready;
    logic [CW-1:0]    countA;
    logic [CW-1:0]    countB;

    stream_demux_1x2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .outA_data  (outA_data),
        .outA_valid (outA_valid),
        .outA_ready (outA_ready),
        .outB_data  (outB_data),
        .outB_valid (outB_valid),
        .outB_ready (outB_ready),
        .countA     (countA),
        .countB     (countB)
    );

    always #5 Clk = ~Clk;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] dut_b[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":countA"}, 64'(countA), 64'(qa.size()));
        chk({tag, ":countB"}, 64'(countB), 64'(qb.size()));
        chk({tag, ":outA_valid"}, 64'(outA_valid), 64'(qa.size() != 0));
        chk({tag, ":outB_valid"}, 64'(outB_valid), 64'(qb.size() != 0));
        chk({tag, ":outA_data"}, 64'(outA_data), (qa.size() != 0) ? 64'(qa[0]) : 64'd0);
        chk({tag, ":outB_data"}, 64'(outB_data), (qb.size() != 0) ? 64'(qb[0]) : 64'd0);
    endtask

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic ra, input logic rb);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        outA_ready = ra;
        outB_ready = rb;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string tag);
        bit pa, pb, xa, xb;
        #1;
        chk({tag, ":in_ready"}, 64'(in_ready),
            64'(in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)));
        pa = in_valid && !in_sel && (qa.size() < DEPTH);
        pb = in_valid &&  in_sel && (qb.size() < DEPTH);
        xa = outA_ready && (qa.size() > 0);
        xb = outB_ready && (qb.size() > 0);
        if (outB_valid && outB_ready)
            dut_b.push_back(outB_data);
        @(posedge Clk);
        if (xa) void'(qa.pop_front());
        if (xb) void'(qb.pop_front());
        if (pa) qa.push_back(in_data);
        if (pb) qb.push_back(in_data);
        #1;
        check_outs(tag);
        @(negedge Clk);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        #1;
        qa.delete();
        qb.delete();
        check_outs(tag);
        chk({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        int nxt;
        bit acc;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        do_reset("rst0");

        // Asynchronous reset between edges while A holds two words
        drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0); step("t1p1");
        drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0); step("t1p2");
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("t1:pre_countA", 64'(countA), 64'd2);
        #2;
        do_reset("t1rst");

        // Routing by select bit
        drive(1'b1, 1'b0, 32'hDEAD0001, 1'b0, 1'b0); step("t2a");
        drive(1'b1, 1'b1, 32'hBEEF0002, 1'b0, 1'b0); step("t2b");
        chk("t2:outA_data", 64'(outA_data), 64'hDEAD0001);
        chk("t2:outB_data", 64'(outB_data), 64'hBEEF0002);
        chk("t2:countA", 64'(countA), 64'd1);
        chk("t2:countB", 64'(countB), 64'd1);
        do_reset("t2rst");

        // Full / backpressure
        drive(1'b1, 1'b0, 32'h11, 1'b0, 1'b0); step("t3p11");
        drive(1'b1, 1'b0, 32'h22, 1'b0, 1'b0); step("t3p22");
        drive(1'b1, 1'b0, 32'h33, 1'b0, 1'b0); #1;
        chk("t3:in_ready_selA_full", 64'(in_ready), 64'd0);
        in_sel = 1'b1; in_valid = 1'b0; #1;
        chk("t3:in_ready_selB", 64'(in_ready), 64'd1);
        @(negedge Clk);
        drive(1'b1, 1'b0, 32'h33, 1'b0, 1'b0); step("t3refuse");
        chk("t3:countA_full", 64'(countA), 64'd2);
        chk("t3:head11", 64'(outA_data), 64'h11);
        drive(1'b1, 1'b0, 32'h33, 1'b1, 1'b0); step("t3pop11");
        chk("t3:head22", 64'(outA_data), 64'h22);
        drive(1'b1, 1'b0, 32'h33, 1'b1, 1'b0); step("t3pop22");
        chk("t3:head33", 64'(outA_data), 64'h33);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0); step("t3pop33");
        chk("t3:emptyA", 64'(outA_valid), 64'd0);
        do_reset("t3rst");

        // Simultaneous push and pop on A
        drive(1'b1, 1'b0, 32'h5, 1'b0, 1'b0); step("t4p5");
        drive(1'b1, 1'b0, 32'h6, 1'b1, 1'b0); step("t4pp6");
        chk("t4:countA", 64'(countA), 64'd1);
        chk("t4:outA_data", 64'(outA_data), 64'h6);
        // Ready on an empty FIFO must not underflow
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step("t4drain");
        drive(1'b0, 1'b1, 32'hFFFF, 1'b1, 1'b1); step("t4idle");
        chk("t4:countB_noufl", 64'(countB), 64'd0);
        do_reset("t4rst");

        // Ordered stream through B with toggling consumer
        dut_b.delete();
        nxt = 1;
        for (int cyc = 0; cyc < 60 && dut_b.size() < 10; cyc++) begin
            drive(nxt <= 10, 1'b1, WIDTH'(nxt), 1'b0, cyc[0]);
            #1;
            acc = in_valid && in_ready;
            step("t5");
            if (acc) nxt++;
            chk("t5:countB_le2", 64'(countB <= CW'(2)), 64'd1);
        end
        chk("t5:num_words", 64'(dut_b.size()), 64'd10);
        for (int i = 0; i < dut_b.size(); i++)
            chk($sformatf("t5:word%0d", i), 64'(dut_b[i]), 64'(i + 1));
        do_reset("t5rst");

        // Random cross traffic
        for (int cyc = 0; cyc < 1000; cyc++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            step("t6");
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int cyc = 0; cyc < 4; cyc++) step("t6drain");
        chk("t6:finalA", 64'(countA), 64'd0);
        chk("t6:finalB", 64'(countB), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
